// File: rtl/a2_serial_sched.sv
// a2_serial_sched: streams a 3-share state one nibble per cycle through a shared
// pipelined datapath and reassembles the delayed results into the output shares.
module a2_serial_sched #(
  parameter int NIBBLES    = 16,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in_s1,
  input  logic [4*NIBBLES-1:0] in_s2,
  input  logic [4*NIBBLES-1:0] in_s3,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] out_s1,
  output logic [4*NIBBLES-1:0] out_s2,
  output logic [4*NIBBLES-1:0] out_s3,
  output logic [3:0]           dp_x1,
  output logic [3:0]           dp_x2,
  output logic [3:0]           dp_x3,
  output logic                 dp_en,
  input  logic [3:0]           dp_y1,
  input  logic [3:0]           dp_y2,
  input  logic [3:0]           dp_y3
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;
  state_e                state_q;
  logic [W-1:0]          sh1_q, sh2_q, sh3_q, out1_q, out2_q, out3_q;
  logic [CW-1:0]         feed_cnt_q, col_cnt_q;
  logic [PIPE_DEPTH-1:0] vld_q;
  logic                  cap;
  assign cap    = vld_q[PIPE_DEPTH-1];
  assign busy   = state_q == FEED || state_q == DRAIN;
  assign done   = state_q == DONE;
  assign dp_en  = state_q == FEED;
  // Shift registers fill with zeros, so after the last nibble they drive 0 to the datapath.
  assign dp_x1  = sh1_q[3:0];
  assign dp_x2  = sh2_q[3:0];
  assign dp_x3  = sh3_q[3:0];
  assign out_s1 = out1_q;
  assign out_s2 = out2_q;
  assign out_s3 = out3_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh1_q      <= '0;
      sh2_q      <= '0;
      sh3_q      <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out3_q     <= '0;
      feed_cnt_q <= '0;
      col_cnt_q  <= '0;
      vld_q      <= '0;
    end else begin
      vld_q <= (vld_q << 1) | PIPE_DEPTH'(state_q == FEED);
      if (cap) begin
        out1_q    <= {dp_y1, out1_q[W-1:4]};
        out2_q    <= {dp_y2, out2_q[W-1:4]};
        out3_q    <= {dp_y3, out3_q[W-1:4]};
        col_cnt_q <= col_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          sh1_q      <= in_s1;
          sh2_q      <= in_s2;
          sh3_q      <= in_s3;
          feed_cnt_q <= '0;
          col_cnt_q  <= '0;
          state_q    <= FEED;
        end
        FEED: begin
          sh1_q      <= sh1_q >> 4;
          sh2_q      <= sh2_q >> 4;
          sh3_q      <= sh3_q >> 4;
          feed_cnt_q <= feed_cnt_q + 1'b1;
          if (feed_cnt_q == CW'(NIBBLES - 1)) state_q <= DRAIN;
        end
        DRAIN: if (cap && col_cnt_q == CW'(NIBBLES - 1)) state_q <= DONE;
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a2_serial_sched.sv
// tb_a2_serial_sched: three builds (PIPE_DEPTH 2,1,4) driven by a shared start, each
// with a delay-line mock datapath that XORs a per-share mask.
module tb_a2_serial_sched;
  logic        clk = 0, rst = 1, start = 0;
  logic [63:0] in1 = 0, in2 = 0, in3 = 0;
  logic [3:0]  m1 = 0, m2 = 0, m3 = 0;
  int          cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int P = g == 0 ? 2 : g == 1 ? 1 : 4;
    logic        busy, done, dp_en;
    logic [3:0]  dp_x1, dp_x2, dp_x3, dp_y1, dp_y2, dp_y3;
    logic [63:0] out_s1, out_s2, out_s3;
    logic [11:0] pipe [P];
    int          done_at = 0, done_cnt = 0;
    a2_serial_sched #(.NIBBLES(16), .PIPE_DEPTH(P)) dut (
      .clk(clk), .rst(rst), .start(start), .in_s1(in1), .in_s2(in2), .in_s3(in3),
      .busy(busy), .done(done), .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
      .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_x3(dp_x3), .dp_en(dp_en),
      .dp_y1(dp_y1), .dp_y2(dp_y2), .dp_y3(dp_y3));
    always @(posedge clk) begin
      pipe[0] <= {dp_x1, dp_x2, dp_x3} ^ {m1, m2, m3};
      for (int i = 1; i < P; i++) pipe[i] <= pipe[i-1];
      if (done) begin
        done_at  <= cyc;
        done_cnt <= done_cnt + 1;
      end
    end
    assign {dp_y1, dp_y2, dp_y3} = pipe[P-1];
  end
  typedef struct {
    logic [63:0] i1, i2, i3;
    logic [3:0]  m1, m2, m3;
    logic [63:0] e1, e2, e3;
  } vec_t;
  vec_t vecs[3];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [63:0] a, b, c, input logic [3:0] x, y, z);
    vec_t v;
    v.i1 = a; v.i2 = b; v.i3 = c; v.m1 = x; v.m2 = y; v.m3 = z;
    v.e1 = a ^ {16{x}}; v.e2 = b ^ {16{y}}; v.e3 = c ^ {16{z}};
    return v;
  endfunction
  task automatic run_pass(input vec_t v, input bit repulse);
    int t, k, d0, d1, d2;
    in1 = v.i1; in2 = v.i2; in3 = v.i3; m1 = v.m1; m2 = v.m2; m3 = v.m3;
    d0 = u[0].done_cnt; d1 = u[1].done_cnt; d2 = u[2].done_cnt;
    @(negedge clk);
    start = 1;
    t = cyc;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= 19; c++) begin
      k = c <= 16 ? 4 * (c - 1) : 0;
      chk("dp_en", 64'(u[0].dp_en), 64'(c <= 16));
      chk("dp_x1", 64'(u[0].dp_x1), c <= 16 ? 64'(v.i1[k+:4]) : 64'h0);
      chk("dp_x2", 64'(u[0].dp_x2), c <= 16 ? 64'(v.i2[k+:4]) : 64'h0);
      chk("dp_x3", 64'(u[0].dp_x3), c <= 16 ? 64'(v.i3[k+:4]) : 64'h0);
      chk("busy", 64'(u[0].busy), 64'(c <= 18));
      chk("done", 64'(u[0].done), 64'(c == 19));
      start = repulse && (c == 5 || c == 17);
      @(negedge clk);
    end
    start = 0;
    repeat (10) begin
      chk("out1_hold", u[0].out_s1, v.e1);
      chk("out2_hold", u[0].out_s2, v.e2);
      chk("out3_hold", u[0].out_s3, v.e3);
      @(negedge clk);
    end
    chk("done_lat_p2", 64'(u[0].done_at - t), 64'd19);
    chk("done_lat_p1", 64'(u[1].done_at - t), 64'd18);
    chk("done_lat_p4", 64'(u[2].done_at - t), 64'd21);
    chk("done_cnt_p2", 64'(u[0].done_cnt - d0), 64'd1);
    chk("done_cnt_p1", 64'(u[1].done_cnt - d1), 64'd1);
    chk("done_cnt_p4", 64'(u[2].done_cnt - d2), 64'd1);
    chk("p1_out1", u[1].out_s1, v.e1);
    chk("p1_out3", u[1].out_s3, v.e3);
    chk("p4_out1", u[2].out_s1, v.e1);
    chk("p4_out2", u[2].out_s2, v.e2);
  endtask
  task automatic rst_test(input vec_t v);
    int d0, d1, d2;
    in1 = v.i1; in2 = v.i2; in3 = v.i3; m1 = v.m1; m2 = v.m2; m3 = v.m3;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    d0 = u[0].done_cnt; d1 = u[1].done_cnt; d2 = u[2].done_cnt;
    chk("rst_busy", 64'(u[0].busy), 64'd0);
    chk("rst_dp_en", 64'(u[0].dp_en), 64'd0);
    chk("rst_dp_x", 64'({u[0].dp_x1, u[0].dp_x2, u[0].dp_x3}), 64'd0);
    chk("rst_out1", u[0].out_s1, 64'd0);
    chk("rst_out2", u[0].out_s2, 64'd0);
    chk("rst_out3", u[0].out_s3, 64'd0);
    chk("rst_p4_out1", u[2].out_s1, 64'd0);
    repeat (30) @(negedge clk);
    chk("rst_no_done_p2", 64'(u[0].done_cnt - d0), 64'd0);
    chk("rst_no_done_p1", 64'(u[1].done_cnt - d1), 64'd0);
    chk("rst_no_done_p4", 64'(u[2].done_cnt - d2), 64'd0);
    run_pass(v, 0);
  endtask
  task automatic held_test(input vec_t v);
    int last = -1, n = 0;
    in1 = v.i1; in2 = v.i2; in3 = v.i3; m1 = v.m1; m2 = v.m2; m3 = v.m3;
    @(negedge clk);
    start = 1;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (!u[0].dp_en) chk("held_idle_x", 64'({u[0].dp_x1, u[0].dp_x2, u[0].dp_x3}), 64'd0);
      if (u[0].done) begin
        n++;
        chk("held_out1", u[0].out_s1, v.e1);
        chk("held_out2", u[0].out_s2, v.e2);
        chk("held_out3", u[0].out_s3, v.e3);
        if (last >= 0) chk("held_spacing", 64'(cyc - last), 64'd20);
        last = cyc;
      end
    end
    start = 0;
    chk("held_dones", 64'(n), 64'd3);
    repeat (30) @(negedge clk);
  endtask
  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 4'h0, 4'h0, 4'h0,
                64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0};
    vecs[1] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 4'h5, 4'h5, 4'h5,
                64'h54761032DCFE98BA, 64'hAB89EFCD23016745, 64'h5555555555555555};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'h1, 4'h2, 4'h3,
                64'hEEEEEEEEEEEEEEEE, 64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC};
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(u[0].busy), 64'd0);
    chk("reset_done", 64'(u[0].done), 64'd0);
    chk("reset_dp_en", 64'(u[0].dp_en), 64'd0);
    chk("reset_dp_x", 64'({u[0].dp_x1, u[0].dp_x2, u[0].dp_x3}), 64'd0);
    chk("reset_out", u[0].out_s1 | u[0].out_s2 | u[0].out_s3, 64'd0);
    rst = 0;
    for (int i = 0; i < 3; i++) run_pass(vecs[i], i == 2);
    rst_test(vecs[1]);
    held_test(vecs[0]);
    for (int i = 0; i < 6; i++)
      run_pass(model({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15))), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/a2_serial_sched.md
Name: a2_serial_sched

Overview:
- Sequencer that shares one 3-share, 4-bit nonlinear datapath (A2 affine layers plus quadratic TI stages, registered internally) across the 16 nibbles of a Midori64 state.
- Captures a 3-share 64-bit state on start and feeds one nibble per share per cycle into the shared datapath.
- Collects the delayed results and reassembles the 3-share output state.
- Sits between the round-state registers and the serialized S-box layer.

Parameters:
- NIBBLES, 16, nibbles per share in the state (state width = 4*NIBBLES).
- PIPE_DEPTH, 2, register stages inside the external datapath; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a pass; sampled only in IDLE.
- in_s1  input  4*NIBBLES  state share 1.
- in_s2  input  4*NIBBLES  state share 2.
- in_s3  input  4*NIBBLES  state share 3.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when out_s* is complete.
- out_s1  output  4*NIBBLES  result share 1.
- out_s2  output  4*NIBBLES  result share 2.
- out_s3  output  4*NIBBLES  result share 3.
- dp_x1  output  4  nibble to datapath, share 1.
- dp_x2  output  4  nibble to datapath, share 2.
- dp_x3  output  4  nibble to datapath, share 3.
- dp_en  output  1  high when dp_x* carries a valid nibble.
- dp_y1  input  4  datapath result, share 1; valid PIPE_DEPTH cycles after presentation.
- dp_y2  input  4  datapath result, share 2; same timing.
- dp_y3  input  4  datapath result, share 3; same timing.

Behaviour:
- Reset values: busy=0, done=0, dp_en=0, dp_x*=0, out_s*=0; FSM=IDLE, all counters 0, valid-tracker cleared.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 on an edge copies in_s1/2/3 into shift registers sh1/2/3, sets feed_cnt=0, and moves to FEED.
  - start while busy is ignored entirely.
- FEED:
  - dp_en=1; dp_xk = shk[3:0], so nibble 0 (bits [3:0]) goes first.
  - On each edge, shk shifts right by 4 and feed_cnt increments.
  - After nibble NIBBLES-1 is presented, move to DRAIN.
- Valid tracker: a PIPE_DEPTH-long shift register of dp_en.
  - When its tail is 1, dp_y* is captured on that edge.
  - Capture shifts dp_yk into the top nibble of outk and shifts outk right by 4, so after NIBBLES captures nibble i sits at bits [4i+3:4i].
  - col_cnt counts captures.
- DRAIN:
  - dp_en=0 and dp_x*=0. Zeros are driven so no stale share reaches the datapath.
  - Move to DONE when col_cnt reaches NIBBLES.
- DONE:
  - done=1 for exactly one cycle, busy=0, then return to IDLE.
  - start asserted in the DONE cycle is not accepted; it must be held or reissued in IDLE.
- Latency:
  - start sampled at edge T; nibble 0 presented in cycle T+1; nibble 15 presented in cycle T+16.
  - Last capture at the edge ending cycle T+16+PIPE_DEPTH.
  - done high in cycle T+17+PIPE_DEPTH (19 for defaults).
  - Throughput: one pass per NIBBLES+PIPE_DEPTH+2 cycles.
- out_s* is updated only by captures and holds its value from done until the next pass's first capture.
- Share separation:
  - Shares are never combined, compared or muxed across one another.
  - Each dp_xk depends only on in_sk; each outk depends only on dp_yk.
- rst at any time, including mid-FEED or mid-DRAIN, forces the reset values on the next edge.
  - In-flight datapath results arriving afterwards are ignored because the tracker is cleared.
  - No done pulse is produced for an aborted pass.
- Counters are sized for NIBBLES and have no wrap-around; the counts are bounded by the FSM.

Test Plan:
- Mock datapath = PIPE_DEPTH-stage delay line (identity).
  - Stimulus: in_s1=64'h0123456789ABCDEF, in_s2=64'hFEDCBA9876543210, in_s3=64'h0, start pulse.
  - Required: dp_x1 sequence F,E,D,…,0 over 16 cycles; dp_x3 stays 0.
  - Required: done in cycle T+19; out_s1/2/3 equal the inputs.
- Mock datapath = per-share XOR 4'h5 after the delay.
  - Required: out_s1 = in_s1 ^ 64'h5555555555555555; same rule for shares 2 and 3.
  - Required: out_s* holds its value for 10 idle cycles after done.
- start re-pulsed at cycles T+5 and T+17.
  - Required: no effect; exactly one done at T+19; busy continuous from T+1 through T+18.
- rst asserted at cycle T+8 for one cycle.
  - Required: next cycle busy=0, dp_en=0, out_s*=0.
  - Required: no done in the following 30 cycles.
  - A fresh start afterwards completes correctly with done 19 cycles later.
- PIPE_DEPTH=1 and PIPE_DEPTH=4 builds with the identity mock.
  - Required: done at T+18 and T+21 respectively; outputs correct.
- start held high continuously.
  - Required: back-to-back passes with done pulses spaced 20 cycles apart (default parameters); dp_x*=0 whenever dp_en=0.
